// File: rtl/int_sequencer_pkg.sv
// rtl/int_sequencer_pkg.sv - state encoding and constants shared by the interrupt sequencer
package int_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DUMMY,
    PUSH_H,
    PUSH_L,
    PUSH_P,
    VEC_L,
    VEC_H
  } seq_state_t;

  localparam logic [7:0]  STACK_PAGE_HI = 8'h01;
  localparam logic [15:0] VEC_NMI_ADDR  = 16'hFFFA;
  localparam logic [15:0] VEC_RES_ADDR  = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_ADDR  = 16'hFFFE;

  localparam logic [7:0]  OP_BRK = 8'h00;

  localparam int P_I = 2;
  localparam int P_B = 4;
  localparam int P_U = 5;

endpackage

// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - 6502 seven-cycle interrupt/BRK/reset micro-sequencer
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_HI,
  parameter logic [15:0] VEC_NMI    = VEC_NMI_ADDR,
  parameter logic [15:0] VEC_RES    = VEC_RES_ADDR,
  parameter logic [15:0] VEC_IRQ    = VEC_IRQ_ADDR
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic        start,
  input  logic        is_brk,
  input  logic        is_res,
  input  logic        nmi_pending,
  input  logic [15:0] pc,
  input  logic [7:0]  p,
  input  logic [7:0]  sp,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        rw,
  output logic        sp_dec,
  output logic        pc_inc,
  output logic        set_i,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        nmi_clr,
  output logic        int_clr,
  output logic        busy
);

  seq_state_t  state;
  logic [15:0] pc_q;
  logic [7:0]  p_q;
  logic        brk_q;
  logic        res_q;
  logic [15:0] vec_q;
  logic [7:0]  lo_q;

  logic [15:0] vec_sel;
  logic [15:0] stack_addr;
  logic [7:0]  p_push;

  // An NMI seen during PUSH_P steals the vector from a BRK/IRQ; reset always keeps its own.
  always_comb begin
    if (res_q)
      vec_sel = VEC_RES;
    else if (nmi_pending)
      vec_sel = VEC_NMI;
    else
      vec_sel = VEC_IRQ;
  end

  assign stack_addr = {STACK_PAGE, sp};

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      state <= IDLE;
      pc_q  <= '0;
      p_q   <= '0;
      brk_q <= 1'b0;
      res_q <= 1'b0;
      vec_q <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc_q  <= pc;
            p_q   <= p;
            brk_q <= is_brk & ~is_res;
            res_q <= is_res;
            state <= DUMMY;
          end
        end
        DUMMY:  state <= PUSH_H;
        PUSH_H: state <= PUSH_L;
        PUSH_L: state <= PUSH_P;
        PUSH_P: begin
          vec_q <= vec_sel;
          state <= VEC_L;
        end
        VEC_L: begin
          lo_q  <= din;
          state <= VEC_H;
        end
        VEC_H:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    addr    = pc;
    dout    = '0;
    rw      = 1'b1;
    sp_dec  = 1'b0;
    pc_inc  = 1'b0;
    set_i   = 1'b0;
    pc_load = 1'b0;
    pc_new  = '0;
    nmi_clr = 1'b0;
    int_clr = 1'b0;
    busy    = (state != IDLE);
    p_push       = p_q;
    p_push[P_U]  = 1'b1;
    p_push[P_B]  = brk_q;
    // Reset sequences walk the stack pointer but never assert a write.
    case (state)
      DUMMY: begin
        addr   = pc_q;
        pc_inc = brk_q;
      end
      PUSH_H: begin
        addr   = stack_addr;
        dout   = pc_q[15:8];
        rw     = res_q;
        sp_dec = 1'b1;
      end
      PUSH_L: begin
        addr   = stack_addr;
        dout   = pc_q[7:0];
        rw     = res_q;
        sp_dec = 1'b1;
      end
      PUSH_P: begin
        addr    = stack_addr;
        dout    = p_push;
        rw      = res_q;
        sp_dec  = 1'b1;
        nmi_clr = ~res_q & nmi_pending;
      end
      VEC_L: begin
        addr  = vec_q;
        set_i = 1'b1;
      end
      VEC_H: begin
        addr    = {vec_q[15:8], vec_q[7:0] + 8'd1};
        pc_new  = {din, lo_q};
        pc_load = 1'b1;
        int_clr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// tb/tb_int_sequencer.sv - scoreboard bench for int_sequencer
module tb_int_sequencer;

  logic        clk_ph1 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_brk = 1'b0;
  logic        is_res = 1'b0;
  logic        nmi_pending = 1'b0;
  logic [15:0] pc = 16'hABCD;
  logic [7:0]  p = 8'h00;
  logic [7:0]  sp = 8'hFF;
  logic [7:0]  din;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        rw, sp_dec, pc_inc, set_i, pc_load, nmi_clr, int_clr, busy;
  logic [15:0] pc_new;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rw;
    logic        sp_dec;
    logic        pc_inc;
    logic        set_i;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        nmi_clr;
    logic        int_clr;
  } exp_t;

  exp_t exp_q[$];

  int_sequencer dut (
    .clk_ph1(clk_ph1), .rst(rst), .start(start), .is_brk(is_brk), .is_res(is_res),
    .nmi_pending(nmi_pending), .pc(pc), .p(p), .sp(sp), .din(din),
    .addr(addr), .dout(dout), .rw(rw), .sp_dec(sp_dec), .pc_inc(pc_inc),
    .set_i(set_i), .pc_load(pc_load), .pc_new(pc_new), .nmi_clr(nmi_clr),
    .int_clr(int_clr), .busy(busy)
  );

  always #5 clk_ph1 = ~clk_ph1;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h78;
      16'hFFFB: return 8'h56;
      16'hFFFC: return 8'hBC;
      16'hFFFD: return 8'h9A;
      16'hFFFE: return 8'h34;
      16'hFFFF: return 8'h12;
      default:  return a[15:8] ^ a[7:0];
    endcase
  endfunction

  always_comb din = mem_rd(addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pushes expected per-cycle outputs, then drives the sequence and pops on each busy cycle.
  task automatic run_seq(input logic [15:0] pc_i, input logic [7:0] p_i, input logic [7:0] sp_i,
                         input logic brk, input logic res, input int nmi_at, input int rst_at,
                         input int restart_at);
    logic [15:0] vec;
    logic        hijack, sp_seen, nmi_done;
    logic [7:0]  p_exp;
    int          last_k, spdec_cnt;
    exp_t        e, o;
    hijack = !res && nmi_at >= 0 && nmi_at <= 3;
    vec    = res ? 16'hFFFC : (hijack ? 16'hFFFA : 16'hFFFE);
    p_exp  = p_i | 8'h20;
    p_exp[4] = brk & ~res;
    last_k = (rst_at >= 0) ? rst_at : 5;
    for (int k = 0; k <= last_k; k++) begin
      e = '{addr: 16'h0, dout: 8'h0, rw: 1'b1, sp_dec: 1'b0, pc_inc: 1'b0, set_i: 1'b0,
            pc_load: 1'b0, pc_new: 16'h0, nmi_clr: 1'b0, int_clr: 1'b0};
      case (k)
        0: begin e.addr = pc_i; e.pc_inc = brk & ~res; end
        1: begin e.addr = {8'h01, sp_i}; e.dout = pc_i[15:8]; e.rw = res; e.sp_dec = 1'b1; end
        2: begin e.addr = {8'h01, sp_i - 8'd1}; e.dout = pc_i[7:0]; e.rw = res; e.sp_dec = 1'b1; end
        3: begin
          e.addr = {8'h01, sp_i - 8'd2}; e.dout = p_exp; e.rw = res; e.sp_dec = 1'b1;
          e.nmi_clr = hijack;
        end
        4: begin e.addr = vec; e.set_i = 1'b1; end
        default: begin
          e.addr = vec + 16'd1; e.pc_load = 1'b1; e.int_clr = 1'b1;
          e.pc_new = {mem_rd(vec + 16'd1), mem_rd(vec)};
        end
      endcase
      exp_q.push_back(e);
    end

    check("idle_busy_pre", busy, 0);
    pc = pc_i; p = p_i; sp = sp_i; is_brk = brk; is_res = res; nmi_pending = 1'b0; start = 1'b1;
    sp_seen = 1'b0; nmi_done = 1'b0; spdec_cnt = 0;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clk_ph1);
      #1;
      start  = (k == restart_at);
      pc     = ~pc_i;
      p      = ~p_i;
      is_brk = ~brk;
      if (sp_seen) sp = sp - 8'd1;
      nmi_pending = (nmi_at >= 0 && k >= nmi_at && !nmi_done);
      rst = (k == rst_at);
      #1;
      check($sformatf("busy_k%0d", k), busy, (k <= last_k) ? 1 : 0);
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          o = '{addr: addr, dout: dout, rw: rw, sp_dec: sp_dec, pc_inc: pc_inc, set_i: set_i,
                pc_load: pc_load, pc_new: pc_new, nmi_clr: nmi_clr, int_clr: int_clr};
          check($sformatf("addr_k%0d", k), o.addr, e.addr);
          check($sformatf("rw_k%0d", k), o.rw, e.rw);
          check($sformatf("pulses_k%0d", k),
                {o.sp_dec, o.pc_inc, o.set_i, o.pc_load, o.nmi_clr, o.int_clr},
                {e.sp_dec, e.pc_inc, e.set_i, e.pc_load, e.nmi_clr, e.int_clr});
          if (!e.rw) check($sformatf("dout_k%0d", k), o.dout, e.dout);
          if (e.pc_load) check("pc_new", o.pc_new, e.pc_new);
        end
      end else begin
        check($sformatf("idle_pulses_k%0d", k), {sp_dec, pc_load, int_clr, nmi_clr, set_i}, 0);
        check($sformatf("idle_rw_k%0d", k), rw, 1);
      end
      if (sp_dec) spdec_cnt++;
      if (nmi_clr) nmi_done = 1'b1;
      sp_seen = sp_dec;
    end
    rst = 1'b0;
    start = 1'b0;
    nmi_pending = 1'b0;
    check("sb_left", exp_q.size(), 0);
    check("spdec_cnt", spdec_cnt, (rst_at >= 0) ? rst_at : 3);
  endtask

  initial begin
    repeat (3) @(posedge clk_ph1);
    #2;
    check("rst_busy", busy, 0);
    check("rst_addr", addr, 16'hABCD);
    check("rst_rw_dout", {rw, dout}, 9'h100);
    check("rst_pulses", {sp_dec, pc_inc, set_i, pc_load, nmi_clr, int_clr}, 0);
    rst = 1'b0;
    @(posedge clk_ph1);
    #2;
    check("idle_busy", busy, 0);

    run_seq(16'h8123, 8'h20, 8'hFD, 1'b0, 1'b0, -1, -1, -1);
    run_seq(16'h4000, 8'h00, 8'hF0, 1'b1, 1'b0, -1, -1, -1);
    run_seq(16'h2222, 8'h04, 8'hF8, 1'b0, 1'b0, 1, -1, -1);
    run_seq(16'h3333, 8'h81, 8'hE0, 1'b0, 1'b0, 4, -1, -1);
    run_seq(16'h1000, 8'h00, 8'h00, 1'b0, 1'b1, -1, -1, -1);
    run_seq(16'h5555, 8'hC3, 8'h80, 1'b1, 1'b1, -1, -1, -1);
    run_seq(16'h6000, 8'h01, 8'hA0, 1'b0, 1'b0, -1, 2, -1);
    run_seq(16'h7001, 8'h02, 8'h90, 1'b0, 1'b0, -1, -1, 2);
    run_seq(16'h0102, 8'hFF, 8'h10, 1'b1, 1'b0, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
